rr_arbiter8: RTL

- Round-robin arbiter that shares one 8-way resource between 8 requesters.
- Internally selects a 3-bit winner index and drives the 3-to-8 one-hot decode of that index as the grant vector.
- Sits in front of any shared datapath the team steers with a one-hot select (bus mux, shared ALU, memory port).
- Grant is held until the winner releases its request. An optional timeout bounds the hold.

---
 rtl/rr_arbiter8.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter8
// Purpose  : 8-way round-robin arbiter with a registered one-hot grant; the
//            grant is held until released. Define RR_TIMEOUT_EN to bound it.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_ptr, w_ptr_nxt;
    logic [2:0]  r_gnt_idx, w_gnt_idx_nxt;
    logic        r_gnt_valid, w_gnt_valid_nxt;
    logic [7:0]  r_gnt;
    logic        r_timeout, w_timeout_nxt;
    logic [15:0] w_req_dbl;
    logic [7:0]  w_req_rot;
    logic [2:0]  w_offset;
    logic [2:0]  w_winner;

    if ((1 << CW) <= MAX_HOLD || MAX_HOLD < 2) begin : g_bad_cfg
        $error("rr_arbiter8: illegal MAX_HOLD/CW combination");
    end

    // Rotate so that the pointer position lands on bit 0, then pick the
    // lowest set bit; adding the pointer back gives the absolute winner.
    assign w_req_dbl = {req, req} >> r_ptr;
    assign w_req_rot = w_req_dbl[7:0];

    always_comb begin
        w_offset = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_offset = 3'(i);
            end
        end
    end

    assign w_winner = r_ptr + w_offset;

`ifdef RR_TIMEOUT_EN
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          w_limit;

    assign w_limit = (r_cnt == CW'(MAX_HOLD - 1));
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;
`ifdef RR_TIMEOUT_EN
        w_cnt_nxt       = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_gnt_idx_nxt   = w_winner;
                    w_gnt_valid_nxt = 1'b1;
                    w_state_nxt     = GRANT;
`ifdef RR_TIMEOUT_EN
                    w_cnt_nxt       = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[r_gnt_idx]) begin
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_idx + 3'd1;
                    w_state_nxt     = IDLE;
                end
`ifdef RR_TIMEOUT_EN
                else if (w_limit) begin
                    w_gnt_valid_nxt = 1'b0;
                    w_ptr_nxt       = r_gnt_idx + 3'd1;
                    w_state_nxt     = IDLE;
                    w_timeout_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt       = r_cnt + 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt     = IDLE;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= 3'd0;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
            r_gnt       <= 8'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt       <= w_gnt_valid_nxt ? (8'd1 << w_gnt_idx_nxt) : 8'd0;
            r_timeout   <= w_timeout_nxt;
        end
    end

`ifdef RR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
    assign timeout = r_timeout;
`else
    logic w_timeout_unused;
    assign w_timeout_unused = r_timeout ^ w_timeout_nxt;
    assign timeout          = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;

endmodule
`default_nettype wire
